// File: rtl/tm_pkg.sv
// Shared types and defaults for the Turing machine input conditioner.
package tm_pkg;

  // Machine phase seen by the operator: program entry, execution, stopped.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } phase_t;

  // Switch bus width used when the top level is not overridden.
  localparam int DATA_W_DEFAULT = 4;

endpackage

// File: rtl/tm_input_conditioner_if.sv
// Bus between the input conditioner and the Turing machine core.
interface tm_input_conditioner_if #(
  parameter int DATA_W    = tm_pkg::DATA_W_DEFAULT,
  parameter int MAX_WORDS = 64
);
  import tm_pkg::*;

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  logic [DATA_W-1:0] input_data;
  logic              Next;
  logic              Done;
  logic              Compute_done;
  phase_t            phase;
  logic [CNT_W-1:0]  word_count;
  logic              overflow;

  modport master (
    output input_data, Next, Done, phase, word_count, overflow,
    input  Compute_done
  );

  modport slave (
    input  input_data, Next, Done, phase, word_count, overflow,
    output Compute_done
  );

endinterface

// File: rtl/tm_debounce.sv
// One button: 2-flop synchronizer, debounce counter, debounced level and
// a one-cycle press event raised the cycle after the level rises.
module tm_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic Reset_n,
  input  logic i_raw,
  output logic o_event,
  output logic o_busy
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_levelD;
  logic          r_event;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it disagrees for a full run; a match restarts the run.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Press event one cycle after the debounced level rises; releases give nothing.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_levelD <= 1'b0;
      r_event  <= 1'b0;
    end else begin
      r_levelD <= r_level;
      r_event  <= r_level & ~r_levelD;
    end
  end

  assign o_event = r_event;
  assign o_busy  = r_level | (r_cnt != '0);

endmodule

// File: rtl/tm_input_conditioner.sv
// Conditions operator switches/buttons into clean strobes and stable data
// for the Turing machine, and tracks the LOAD/RUN/HALT phase.
module tm_input_conditioner
  import tm_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int MAX_WORDS       = 64,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] raw_data,
  input  logic              raw_next,
  input  logic              raw_done,
  tm_input_conditioner_if.master tm_bus
);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_WORDS);

  logic [DATA_W-1:0] r_dataSync1;
  logic [DATA_W-1:0] r_dataSync2;
  logic [DATA_W-1:0] r_inputData;
  logic              w_nextEvent;
  logic              w_nextBusy;
  logic              w_doneEvent;
  logic              w_unused_doneBusy;
  phase_t            r_phase;
  phase_t            w_phaseNext;
  logic              w_fwdNext;
  logic              w_fwdDone;
  logic              w_countInc;
  logic              w_setOvf;
  logic              r_next;
  logic              r_done;
  logic [CNT_W-1:0]  r_wordCount;
  logic              r_overflow;

  tm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nextDebounce (
    .clock   (clock),
    .Reset_n (Reset_n),
    .i_raw   (raw_next),
    .o_event (w_nextEvent),
    .o_busy  (w_nextBusy)
  );

  tm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_doneDebounce (
    .clock   (clock),
    .Reset_n (Reset_n),
    .i_raw   (raw_done),
    .o_event (w_doneEvent),
    .o_busy  (w_unused_doneBusy)
  );

  // Synchronize switches; hold the presented word while a Next press is in flight.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dataSync1 <= '0;
      r_dataSync2 <= '0;
      r_inputData <= '0;
    end else begin
      r_dataSync1 <= raw_data;
      r_dataSync2 <= r_dataSync1;
      if (!w_nextBusy) r_inputData <= r_dataSync2;
    end
  end

  // Phase register.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) r_phase <= LOAD;
    else          r_phase <= w_phaseNext;
  end

  // Phase transitions: halt wins everywhere, Done ends LOAD, HALT is sticky.
  always_comb begin
    w_phaseNext = r_phase;
    if (tm_bus.Compute_done) begin
      w_phaseNext = HALT;
    end else if (r_phase == LOAD && w_doneEvent) begin
      w_phaseNext = RUN;
    end
  end

  // Decide which button events become strobes in the current phase.
  always_comb begin
    w_fwdNext  = 1'b0;
    w_fwdDone  = 1'b0;
    w_countInc = 1'b0;
    w_setOvf   = 1'b0;
    if (!tm_bus.Compute_done) begin
      case (r_phase)
        LOAD: begin
          if (w_doneEvent) begin
            w_fwdDone = 1'b1;
          end else if (w_nextEvent) begin
            if (r_wordCount < MAX_COUNT) begin
              w_fwdNext  = 1'b1;
              w_countInc = 1'b1;
            end else begin
              w_setOvf = 1'b1;
            end
          end
        end
        RUN: w_fwdNext = w_nextEvent;
        default: ;
      endcase
    end
  end

  // Register strobes, the program word count and the sticky overflow flag.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_next      <= 1'b0;
      r_done      <= 1'b0;
      r_wordCount <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_next <= w_fwdNext;
      r_done <= w_fwdDone;
      if (w_countInc) r_wordCount <= r_wordCount + 1'b1;
      if (w_setOvf)   r_overflow  <= 1'b1;
    end
  end

  assign tm_bus.input_data = r_inputData;
  assign tm_bus.Next       = r_next;
  assign tm_bus.Done       = r_done;
  assign tm_bus.phase      = r_phase;
  assign tm_bus.word_count = r_wordCount;
  assign tm_bus.overflow   = r_overflow;

endmodule

// File: tb/tb_tm_input_conditioner.sv
// Directed bench for tm_input_conditioner with a strobe scoreboard.
module tb_tm_input_conditioner;
  import tm_pkg::*;

  localparam int DATA_W    = 4;
  localparam int MAX_WORDS = 64;
  localparam int DEB       = 4;

  logic              clock    = 1'b0;
  logic              Reset_n  = 1'b0;
  logic [DATA_W-1:0] raw_data = '0;
  logic              raw_next = 1'b0;
  logic              raw_done = 1'b0;

  tm_input_conditioner_if #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) bus ();

  tm_input_conditioner #(
    .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock    (clock),
    .Reset_n  (Reset_n),
    .raw_data (raw_data),
    .raw_next (raw_next),
    .raw_done (raw_done),
    .tm_bus   (bus.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit                isDone;
    bit                checkData;
    logic [DATA_W-1:0] data;
  } pulse_t;

  pulse_t sb[$];
  pulse_t expPulse;
  int     checks = 0;
  int     errors = 0;
  bit     prevPulse = 1'b0;

  // Single comparison point: counts every check and every failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press one or both buttons cleanly, recording the strobe the model predicts.
  task automatic applyStimulus(input bit doNext, input bit doDone, input logic [DATA_W-1:0] data,
                               input int hold, input bit expNext, input bit expDone);
    @(posedge clock); #1;
    raw_data = data;
    repeat (4) @(posedge clock);
    #1;
    if (expDone)      sb.push_back('{isDone: 1'b1, checkData: 1'b0, data: '0});
    else if (expNext) sb.push_back('{isDone: 1'b0, checkData: 1'b1, data: data});
    raw_next = doNext;
    raw_done = doDone;
    repeat (hold) @(posedge clock);
    #1;
    raw_next = 1'b0;
    raw_done = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    checkOutput("pulseDrained", sb.size(), 0);
    sb.delete();
  endtask

  // Strobe monitor: every pulse must match the next scoreboard entry.
  always @(negedge clock) begin
    if (bus.Next || bus.Done) begin
      checkOutput("strobesExclusive", 32'(bus.Next & bus.Done), 0);
      checkOutput("strobeOneCycle", 32'(prevPulse), 0);
      if (sb.size() == 0) begin
        checkOutput(bus.Next ? "unexpectedNext" : "unexpectedDone", 1, 0);
      end else begin
        expPulse = sb.pop_front();
        checkOutput("strobeKind", 32'(bus.Done), 32'(expPulse.isDone));
        if (expPulse.checkData) checkOutput("strobeData", 32'(bus.input_data), 32'(expPulse.data));
      end
    end
    prevPulse = bus.Next | bus.Done;
  end

  initial begin
    int lat;
    bus.Compute_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rstInputData", 32'(bus.input_data), 0);
    checkOutput("rstNext", 32'(bus.Next), 0);
    checkOutput("rstDone", 32'(bus.Done), 0);
    checkOutput("rstPhase", 32'(bus.phase), 32'(LOAD));
    checkOutput("rstWordCount", 32'(bus.word_count), 0);
    checkOutput("rstOverflow", 32'(bus.overflow), 0);
    @(posedge clock); #1;
    Reset_n = 1'b1;

    // Bouncy Next press gives a single strobe
    repeat (3) @(posedge clock);
    #1;
    sb.push_back('{isDone: 1'b0, checkData: 1'b1, data: '0});
    for (int i = 0; i < 5; i++) begin
      raw_next = (i % 2 == 0);
      @(posedge clock); #1;
    end
    raw_next = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    raw_next = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    checkOutput("bounceDrained", sb.size(), 0);
    sb.delete();
    checkOutput("bounceWordCount", 32'(bus.word_count), 1);

    // Latency from first sampling edge to the strobe
    @(posedge clock); #1;
    raw_data = 4'd5;
    repeat (4) @(posedge clock);
    #1;
    sb.push_back('{isDone: 1'b0, checkData: 1'b1, data: 4'd5});
    raw_next = 1'b1;
    @(posedge clock);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus.Next) begin
        lat = i;
        break;
      end
    end
    checkOutput("nextLatency", 32'(lat - 1), 32'(2 + DEB + 1));
    repeat (6) @(posedge clock);
    #1;
    raw_next = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    checkOutput("latencyDrained", sb.size(), 0);
    sb.delete();
    checkOutput("latencyWordCount", 32'(bus.word_count), 2);

    // Data freeze while Next is held
    @(posedge clock); #1;
    raw_data = 4'd3;
    repeat (4) @(posedge clock);
    #1;
    sb.push_back('{isDone: 1'b0, checkData: 1'b1, data: 4'd3});
    raw_next = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    raw_data = 4'd1;
    repeat (9) @(posedge clock);
    @(negedge clock);
    checkOutput("dataFrozenHeld", 32'(bus.input_data), 3);
    @(posedge clock); #1;
    raw_next = 1'b0;
    repeat (2 + DEB + 3) @(posedge clock);
    @(negedge clock);
    checkOutput("dataAfterRelease", 32'(bus.input_data), 1);
    checkOutput("freezeDrained", sb.size(), 0);
    sb.delete();
    checkOutput("freezeWordCount", 32'(bus.word_count), 3);

    // Fill the program memory, then one press too many
    for (int k = 0; k < MAX_WORDS - 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'($urandom_range(0, 15)), 12, 1'b1, 1'b0);
    end
    checkOutput("fullWordCount", 32'(bus.word_count), MAX_WORDS);
    checkOutput("fullNoOverflow", 32'(bus.overflow), 0);
    applyStimulus(1'b1, 1'b0, 4'd9, 12, 1'b0, 1'b0);
    checkOutput("ovfWordCount", 32'(bus.word_count), MAX_WORDS);
    checkOutput("ovfFlag", 32'(bus.overflow), 1);

    // Done moves to RUN; later Done is ignored; Next still forwarded
    applyStimulus(1'b0, 1'b1, 4'd0, 12, 1'b0, 1'b1);
    checkOutput("runPhase", 32'(bus.phase), 32'(RUN));
    applyStimulus(1'b0, 1'b1, 4'd0, 12, 1'b0, 1'b0);
    checkOutput("runPhaseAfterDone", 32'(bus.phase), 32'(RUN));
    applyStimulus(1'b1, 1'b0, 4'd7, 12, 1'b1, 1'b0);
    checkOutput("runWordCount", 32'(bus.word_count), MAX_WORDS);

    // Compute_done halts and suppresses every strobe
    @(posedge clock); #1;
    bus.Compute_done = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd2, 12, 1'b0, 1'b0);
    checkOutput("haltPhase", 32'(bus.phase), 32'(HALT));
    bus.Compute_done = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'd2, 12, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd2, 12, 1'b0, 1'b0);
    checkOutput("haltSticky", 32'(bus.phase), 32'(HALT));

    // Reset two cycles into a Next debounce
    @(posedge clock); #1;
    raw_data = 4'd9;
    repeat (4) @(posedge clock);
    #1;
    raw_next = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    Reset_n  = 1'b0;
    raw_next = 1'b0;
    #1;
    checkOutput("midRstInputData", 32'(bus.input_data), 0);
    checkOutput("midRstNext", 32'(bus.Next), 0);
    checkOutput("midRstDone", 32'(bus.Done), 0);
    checkOutput("midRstPhase", 32'(bus.phase), 32'(LOAD));
    checkOutput("midRstWordCount", 32'(bus.word_count), 0);
    checkOutput("midRstOverflow", 32'(bus.overflow), 0);
    repeat (2) @(posedge clock);
    #1;
    Reset_n = 1'b1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    checkOutput("midRstNoPulse", sb.size(), 0);
    checkOutput("midRstCountAfter", 32'(bus.word_count), 0);

    // Simultaneous Next and Done in LOAD: Done wins
    applyStimulus(1'b1, 1'b1, 4'd6, 12, 1'b0, 1'b1);
    checkOutput("simulPhase", 32'(bus.phase), 32'(RUN));
    checkOutput("simulWordCount", 32'(bus.word_count), 0);
    checkOutput("simulOverflow", 32'(bus.overflow), 0);

    // Button held across reset release is still debounced into a press
    @(posedge clock); #1;
    Reset_n  = 1'b0;
    raw_next = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    sb.push_back('{isDone: 1'b0, checkData: 1'b0, data: '0});
    Reset_n = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    raw_next = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    checkOutput("heldRstDrained", sb.size(), 0);
    sb.delete();
    checkOutput("heldRstWordCount", 32'(bus.word_count), 1);
    checkOutput("heldRstPhase", 32'(bus.phase), 32'(LOAD));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
